// File: rtl/mesh_local_port_queue.sv
// mesh_local_port_queue: TX/RX FWFT buffering between a bank and its mesh router LOCAL port, with packet counters.
module mesh_lpq_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [W-1:0]             in_data,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [W-1:0]             out_data,
  output logic [$clog2(DEPTH):0]   occ_next
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr;
  logic [AW-1:0] r_rd;
  logic [AW:0]   r_occ;
  logic          w_push;
  logic          w_pop;
  logic          w_clr;
  assign w_clr     = rst || flush;
  assign in_ready  = (r_occ != (AW+1)'(DEPTH)) && !w_clr;
  assign out_valid = (r_occ != '0) && !rst;
  assign out_data  = r_mem[r_rd];
  assign w_push    = in_valid && in_ready;
  assign w_pop     = out_valid && out_ready;
  assign occ_next  = w_clr ? '0 : r_occ + (AW+1)'(w_push) - (AW+1)'(w_pop);
  always_ff @(posedge clk) begin
    r_occ <= occ_next;
    r_wr  <= w_clr ? '0 : r_wr + AW'(w_push);
    r_rd  <= w_clr ? '0 : r_rd + AW'(w_pop);
  end
  // storage needs no reset: occupancy alone decides what is visible
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr] <= in_data;
  end
endmodule

module mesh_local_port_queue #(
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int CNT_W    = 16,
  parameter int PKT_W    = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             bank_valid,
  output logic             bank_ready,
  input  logic [PKT_W-1:0] bank_pkt,
  output logic             mesh_valid,
  input  logic             mesh_ready,
  output logic [PKT_W-1:0] mesh_pkt,
  input  logic             dlv_valid,
  output logic             dlv_ready,
  input  logic [PKT_W-1:0] dlv_pkt,
  output logic             rcv_valid,
  input  logic             rcv_ready,
  output logic [PKT_W-1:0] rcv_pkt,
  output logic [CNT_W-1:0] tx_count,
  output logic [CNT_W-1:0] rx_count,
  output logic             idle
);
  logic [$clog2(TX_DEPTH):0] w_tx_next;
  logic [$clog2(RX_DEPTH):0] w_rx_next;
  logic [CNT_W-1:0]          r_tx_cnt;
  logic [CNT_W-1:0]          r_rx_cnt;
  logic                      r_idle;
  mesh_lpq_fifo #(.DEPTH(TX_DEPTH), .W(PKT_W)) u_tx (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(bank_valid), .in_ready(bank_ready), .in_data(bank_pkt),
    .out_valid(mesh_valid), .out_ready(mesh_ready), .out_data(mesh_pkt),
    .occ_next(w_tx_next)
  );
  mesh_lpq_fifo #(.DEPTH(RX_DEPTH), .W(PKT_W)) u_rx (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(dlv_valid), .in_ready(dlv_ready), .in_data(dlv_pkt),
    .out_valid(rcv_valid), .out_ready(rcv_ready), .out_data(rcv_pkt),
    .occ_next(w_rx_next)
  );
  // counters see handshakes even in a flush cycle; only rst clears them
  always_ff @(posedge clk) begin
    r_tx_cnt <= rst ? '0 : r_tx_cnt + CNT_W'(mesh_valid && mesh_ready);
    r_rx_cnt <= rst ? '0 : r_rx_cnt + CNT_W'(dlv_valid && dlv_ready);
    r_idle   <= (w_tx_next == '0) && (w_rx_next == '0);
  end
  assign tx_count = r_tx_cnt;
  assign rx_count = r_rx_cnt;
  assign idle     = r_idle;
endmodule

// File: tb/tb_mesh_local_port_queue.sv
// tb_mesh_local_port_queue: random and directed stimulus checked against a queue-based reference model.
module tb_mesh_local_port_queue;
  localparam int D = 4;
  localparam int CW = 4;
  logic clk = 0;
  logic rst, flush, bank_valid, mesh_ready, dlv_valid, rcv_ready;
  logic [31:0] bank_pkt, dlv_pkt;
  logic bank_ready, mesh_valid, dlv_ready, rcv_valid, idle;
  logic [31:0] mesh_pkt, rcv_pkt;
  logic [CW-1:0] tx_count, rx_count;
  int n_chk = 0;
  int n_fail = 0;
  logic [31:0] txq[$];
  logic [31:0] rxq[$];
  int m_tx_cnt = 0;
  int m_rx_cnt = 0;
  logic m_idle = 1'b1;

  always #5 clk = ~clk;

  mesh_local_port_queue #(.TX_DEPTH(D), .RX_DEPTH(D), .CNT_W(CW), .PKT_W(32)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .bank_valid(bank_valid), .bank_ready(bank_ready), .bank_pkt(bank_pkt),
    .mesh_valid(mesh_valid), .mesh_ready(mesh_ready), .mesh_pkt(mesh_pkt),
    .dlv_valid(dlv_valid), .dlv_ready(dlv_ready), .dlv_pkt(dlv_pkt),
    .rcv_valid(rcv_valid), .rcv_ready(rcv_ready), .rcv_pkt(rcv_pkt),
    .tx_count(tx_count), .rx_count(rx_count), .idle(idle)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input logic r, input logic f, input logic bv, input logic mr,
                      input logic dv, input logic rr);
    logic e_br, e_dr, e_mv, e_rv, m_fire, b_fire, d_fire, r_fire;
    @(negedge clk);
    rst = r; flush = f; bank_valid = bv; mesh_ready = mr; dlv_valid = dv; rcv_ready = rr;
    bank_pkt = $urandom; dlv_pkt = $urandom;
    #1;
    e_br = !r && !f && txq.size() < D;
    e_dr = !r && !f && rxq.size() < D;
    e_mv = !r && txq.size() > 0;
    e_rv = !r && rxq.size() > 0;
    chk("bank_ready", 32'(bank_ready), 32'(e_br));
    chk("dlv_ready", 32'(dlv_ready), 32'(e_dr));
    chk("mesh_valid", 32'(mesh_valid), 32'(e_mv));
    chk("rcv_valid", 32'(rcv_valid), 32'(e_rv));
    if (e_mv) chk("mesh_pkt", mesh_pkt, txq[0]);
    if (e_rv) chk("rcv_pkt", rcv_pkt, rxq[0]);
    chk("tx_count", 32'(tx_count), 32'(m_tx_cnt));
    chk("rx_count", 32'(rx_count), 32'(m_rx_cnt));
    chk("idle", 32'(idle), 32'(m_idle));
    b_fire = bv && e_br;
    m_fire = mr && e_mv;
    d_fire = dv && e_dr;
    r_fire = rr && e_rv;
    @(posedge clk);
    if (r) begin
      txq.delete(); rxq.delete();
      m_tx_cnt = 0; m_rx_cnt = 0;
    end else begin
      m_tx_cnt = (m_tx_cnt + int'(m_fire)) % (1 << CW);
      m_rx_cnt = (m_rx_cnt + int'(d_fire)) % (1 << CW);
      if (f) begin
        txq.delete(); rxq.delete();
      end else begin
        if (m_fire) void'(txq.pop_front());
        if (b_fire) txq.push_back(bank_pkt);
        if (r_fire) void'(rxq.pop_front());
        if (d_fire) rxq.push_back(dlv_pkt);
      end
    end
    m_idle = (txq.size() == 0) && (rxq.size() == 0);
  endtask

  initial begin
    rst = 1; flush = 0; bank_valid = 0; mesh_ready = 0; dlv_valid = 0; rcv_ready = 0;
    bank_pkt = '0; dlv_pkt = '0;
    repeat (2) step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    repeat (5) step(0, 0, 1, 0, 0, 0);
    repeat (5) step(0, 0, 0, 1, 0, 0);
    repeat (20) step(0, 0, 1, 1, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0);
    repeat (5) step(0, 0, 0, 0, 1, 0);
    repeat (6) step(0, 0, 0, 0, 0, 1);
    repeat (3) step(0, 0, 1, 0, 0, 0);
    repeat (2) step(0, 0, 0, 0, 1, 0);
    step(0, 1, 1, 1, 1, 1);
    repeat (2) step(0, 0, 0, 0, 0, 0);
    repeat (6) step(0, 0, 1, 1, 1, 0);
    step(1, 0, 1, 1, 1, 1);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 3000; i++) begin
      int bias;
      bias = (i / 500) % 3;
      step($urandom_range(0, 199) == 0, $urandom_range(0, 59) == 0,
           $urandom_range(0, 3) > bias - 1 ? 1'b1 : 1'b0,
           $urandom_range(0, 3) > bias ? 1'b1 : 1'b0,
           $urandom_range(0, 3) > 2 - bias ? 1'b1 : 1'b0,
           $urandom_range(0, 1) == 1);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
